// File: rtl/player_mover.sv
// Player-motion engine: applies a keyboard turn/step to the current pose,
// checking each axis against the map grid separately so the player slides along walls.
module player_mover #(
   parameter int POS_X_W    = 14,
   parameter int POS_Y_W    = 13,
   parameter int ANG_W      = 8,
   parameter int CELL_SHIFT = 8,
   parameter int TRIG_W     = 10,
   parameter int MOVE_STEP  = 64,
   parameter int TURN_STEP  = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   output logic                             done,
   output logic                             busy,
   input  logic                             key_fwd,
   input  logic                             key_back,
   input  logic                             key_left,
   input  logic                             key_right,
   input  logic [POS_X_W-1:0]               cur_pos_x,
   input  logic [POS_Y_W-1:0]               cur_pos_y,
   input  logic [ANG_W-1:0]                 cur_angle,
   output logic [POS_X_W-1:0]               next_pos_x,
   output logic [POS_Y_W-1:0]               next_pos_y,
   output logic [ANG_W-1:0]                 next_angle,
   output logic [ANG_W-1:0]                 trig_angle,
   input  logic signed [TRIG_W-1:0]         trig_cos,
   input  logic signed [TRIG_W-1:0]         trig_sin,
   output logic [POS_X_W-CELL_SHIFT-1:0]    grid_x,
   output logic [POS_Y_W-CELL_SHIFT-1:0]    grid_y,
   input  logic [2:0]                       grid_out
);

   localparam int MS_W   = $clog2(MOVE_STEP + 1) + 1;
   localparam int PROD_W = TRIG_W + MS_W + 1;
   localparam int CX_W   = POS_X_W + 2;
   localparam int CY_W   = POS_Y_W + 2;
   localparam logic signed [PROD_W-1:0] STEP = PROD_W'(MOVE_STEP);

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_CALC, S_ADDR_X, S_CHK_X, S_ADDR_Y, S_CHK_Y, S_DONE
   } state_t;

   state_t r_state, w_nextState;

   logic                          r_keyFwd, r_keyBack;
   logic [POS_X_W-1:0]            r_curX, r_newX, r_nextX;
   logic [POS_Y_W-1:0]            r_curY, r_nextY;
   logic [ANG_W-1:0]              r_ang, r_nextAng, r_trigAngle;
   logic signed [CX_W-1:0]        r_candX;
   logic signed [CY_W-1:0]        r_candY;
   logic [POS_X_W-CELL_SHIFT-1:0] r_gridX;
   logic [POS_Y_W-CELL_SHIFT-1:0] r_gridY;

   logic [ANG_W-1:0]              w_ang;
   logic                          w_fwdOnly, w_backOnly;
   logic signed [PROD_W-1:0]      w_prodX, w_prodY, w_scaledX, w_scaledY, w_dx, w_dy;
   logic signed [CX_W-1:0]        w_candX;
   logic signed [CY_W-1:0]        w_candY;
   logic                          w_xOk, w_yOk;
   logic [POS_X_W-1:0]            w_newX;
   logic [POS_Y_W-1:0]            w_newY;

   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:   if (start) w_nextState = S_TRIG;
         S_TRIG:   w_nextState = S_CALC;
         S_CALC:   w_nextState = S_ADDR_X;
         S_ADDR_X: w_nextState = S_CHK_X;
         S_CHK_X:  w_nextState = S_ADDR_Y;
         S_ADDR_Y: w_nextState = S_CHK_Y;
         S_CHK_Y:  w_nextState = S_DONE;
         S_DONE:   w_nextState = S_IDLE;
         default:  w_nextState = S_IDLE;
      endcase
   end

   // Opposing turn keys cancel; angle wraps naturally at 2^ANG_W.
   always_comb begin
      w_ang = cur_angle;
      if (key_right && !key_left)      w_ang = cur_angle + ANG_W'(TURN_STEP);
      else if (key_left && !key_right) w_ang = cur_angle - ANG_W'(TURN_STEP);
   end

   // Sign is applied before the shift so negative steps floor like the reference model.
   assign w_fwdOnly  = r_keyFwd & ~r_keyBack;
   assign w_backOnly = r_keyBack & ~r_keyFwd;
   assign w_prodX    = PROD_W'(trig_cos) * STEP;
   assign w_prodY    = PROD_W'(trig_sin) * STEP;
   assign w_scaledX  = w_fwdOnly ? w_prodX : (w_backOnly ? -w_prodX : '0);
   assign w_scaledY  = w_fwdOnly ? w_prodY : (w_backOnly ? -w_prodY : '0);
   assign w_dx       = w_scaledX >>> (TRIG_W - 2);
   assign w_dy       = w_scaledY >>> (TRIG_W - 2);
   assign w_candX    = $signed({2'b00, r_curX}) + CX_W'(w_dx);
   assign w_candY    = $signed({2'b00, r_curY}) + CY_W'(w_dy);

   // Top two bits clear means 0 <= cand < 2^POS_W.
   assign w_xOk  = (r_candX[CX_W-1:CX_W-2] == 2'b00) && (grid_out == 3'd0);
   assign w_yOk  = (r_candY[CY_W-1:CY_W-2] == 2'b00) && (grid_out == 3'd0);
   assign w_newX = w_xOk ? r_candX[POS_X_W-1:0] : r_curX;
   assign w_newY = w_yOk ? r_candY[POS_Y_W-1:0] : r_curY;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_keyFwd    <= 1'b0;
         r_keyBack   <= 1'b0;
         r_curX      <= '0;
         r_curY      <= '0;
         r_ang       <= '0;
         r_trigAngle <= '0;
         r_candX     <= '0;
         r_candY     <= '0;
         r_newX      <= '0;
         r_gridX     <= '0;
         r_gridY     <= '0;
         r_nextX     <= '0;
         r_nextY     <= '0;
         r_nextAng   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_keyFwd    <= key_fwd;
                  r_keyBack   <= key_back;
                  r_curX      <= cur_pos_x;
                  r_curY      <= cur_pos_y;
                  r_ang       <= w_ang;
                  r_trigAngle <= w_ang;
               end
            end
            S_CALC: begin
               r_candX <= w_candX;
               r_candY <= w_candY;
               r_gridX <= w_candX[POS_X_W-1:CELL_SHIFT];
               r_gridY <= r_curY[POS_Y_W-1:CELL_SHIFT];
            end
            // The y probe uses the already-resolved x so sliding sees the correct cell.
            S_CHK_X: begin
               r_newX  <= w_newX;
               r_gridX <= w_newX[POS_X_W-1:CELL_SHIFT];
               r_gridY <= r_candY[POS_Y_W-1:CELL_SHIFT];
            end
            S_CHK_Y: begin
               r_nextX   <= r_newX;
               r_nextY   <= w_newY;
               r_nextAng <= r_ang;
            end
            default: ;
         endcase
      end
   end

   assign done       = (r_state == S_DONE);
   assign busy       = (r_state != S_IDLE);
   assign next_pos_x = r_nextX;
   assign next_pos_y = r_nextY;
   assign next_angle = r_nextAng;
   assign trig_angle = r_trigAngle;
   assign grid_x     = r_gridX;
   assign grid_y     = r_gridY;

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: stimulus pushes expected poses, a negedge
// monitor pops and compares them whenever done is presented.
module tb_player_mover;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic               done, busy;
   logic               key_fwd = 1'b0, key_back = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic [13:0]        cur_pos_x = '0;
   logic [12:0]        cur_pos_y = '0;
   logic [7:0]         cur_angle = '0;
   logic [13:0]        next_pos_x;
   logic [12:0]        next_pos_y;
   logic [7:0]         next_angle;
   logic [7:0]         trig_angle;
   logic signed [9:0]  trig_cos = '0, trig_sin = '0;
   logic [5:0]         grid_x;
   logic [4:0]         grid_y;
   logic [2:0]         grid_out = '0;

   logic [2:0]         gridMem [0:63][0:31];
   int                 cyc = 0;
   int                 checks = 0;
   int                 errors = 0;

   typedef struct {
      logic [13:0] x;
      logic [12:0] y;
      logic [7:0]  ang;
      int          issueCyc;
      logic        chkGrid;
      logic [5:0]  gx;
      logic [4:0]  gy;
   } expT;

   expT scoreQ [$];

   player_mover dut (
      .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
      .key_fwd(key_fwd), .key_back(key_back), .key_left(key_left), .key_right(key_right),
      .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
      .next_pos_x(next_pos_x), .next_pos_y(next_pos_y), .next_angle(next_angle),
      .trig_angle(trig_angle), .trig_cos(trig_cos), .trig_sin(trig_sin),
      .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out)
   );

   always #5 clock = ~clock;

   // Cycle counter used to measure start-to-done latency.
   always @(posedge clock) cyc <= cyc + 1;

   // Grid RAM model with one-cycle read latency.
   always @(posedge clock) grid_out <= gridMem[grid_x][grid_y];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: probes grid address in ADDR_X and compares the pose on every done.
   always @(negedge clock) begin : monitor
      expT e;
      if (reset && scoreQ.size() > 0 && scoreQ[0].chkGrid && cyc == scoreQ[0].issueCyc + 3) begin
         checkOutput("grid_x_addr_x", 32'(grid_x), 32'(scoreQ[0].gx));
         checkOutput("grid_y_addr_x", 32'(grid_y), 32'(scoreQ[0].gy));
         checkOutput("busy_mid",      32'(busy),   32'd1);
      end
      if (done) begin
         if (scoreQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1 expected done=0");
         end else begin
            e = scoreQ.pop_front();
            checkOutput("next_pos_x", 32'(next_pos_x), 32'(e.x));
            checkOutput("next_pos_y", 32'(next_pos_y), 32'(e.y));
            checkOutput("next_angle", 32'(next_angle), 32'(e.ang));
            checkOutput("latency",    32'(cyc - e.issueCyc), 32'd7);
         end
      end
   end

   task automatic applyStimulus(
      input logic [13:0] px, input logic [12:0] py, input logic [7:0] pa,
      input logic kf, input logic kb, input logic kl, input logic kr,
      input logic signed [9:0] cosv, input logic signed [9:0] sinv,
      input logic [13:0] ex, input logic [12:0] ey, input logic [7:0] ea,
      input logic chk, input logic [5:0] gx, input logic [4:0] gy);
      expT e;
      @(negedge clock);
      cur_pos_x = px; cur_pos_y = py; cur_angle = pa;
      key_fwd = kf; key_back = kb; key_left = kl; key_right = kr;
      trig_cos = cosv; trig_sin = sinv;
      start = 1'b1;
      e.x = ex; e.y = ey; e.ang = ea; e.issueCyc = cyc;
      e.chkGrid = chk; e.gx = gx; e.gy = gy;
      scoreQ.push_back(e);
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic pulseStart();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      for (int i = 0; i < 20; i++) begin
         if (scoreQ.size() == 0) break;
         @(negedge clock);
      end
      if (scoreQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout_%s: got %0d pending expected 0", name, scoreQ.size());
         scoreQ.delete();
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_done"},       32'(done),       32'd0);
      checkOutput({tag, "_busy"},       32'(busy),       32'd0);
      checkOutput({tag, "_next_pos_x"}, 32'(next_pos_x), 32'd0);
      checkOutput({tag, "_next_pos_y"}, 32'(next_pos_y), 32'd0);
      checkOutput({tag, "_next_angle"}, 32'(next_angle), 32'd0);
      checkOutput({tag, "_trig_angle"}, 32'(trig_angle), 32'd0);
      checkOutput({tag, "_grid_x"},     32'(grid_x),     32'd0);
      checkOutput({tag, "_grid_y"},     32'(grid_y),     32'd0);
   endtask

   initial begin
      for (int gxi = 0; gxi < 64; gxi++)
         for (int gyi = 0; gyi < 32; gyi++)
            gridMem[gxi][gyi] = 3'd0;

      repeat (3) @(negedge clock);
      checkResetState("reset");
      reset = 1'b1;

      $display("[TB] forward move, empty grid");
      applyStimulus(14'd1000, 13'd1000, 8'd0, 1,0,0,0, 10'sd256, 10'sd0, 14'd1064, 13'd1000, 8'd0, 1, 6'd4, 5'd3);
      waitIdle("fwd");

      $display("[TB] forward move blocked by wall");
      gridMem[4][3] = 3'd1;
      applyStimulus(14'd1000, 13'd1000, 8'd0, 1,0,0,0, 10'sd256, 10'sd0, 14'd1000, 13'd1000, 8'd0, 1, 6'd4, 5'd3);
      waitIdle("wall");

      $display("[TB] wall slide");
      applyStimulus(14'd1000, 13'd1000, 8'd32, 1,0,0,0, 10'sd181, 10'sd181, 14'd1000, 13'd1045, 8'd32, 1, 6'd4, 5'd3);
      waitIdle("slide");
      gridMem[4][3] = 3'd0;

      $display("[TB] turn wrap");
      applyStimulus(14'd1000, 13'd1000, 8'd2,   0,0,1,0, 10'sd256, 10'sd0, 14'd1000, 13'd1000, 8'd254, 1, 6'd3, 5'd3);
      waitIdle("turn_left");
      applyStimulus(14'd1000, 13'd1000, 8'd254, 0,0,0,1, 10'sd256, 10'sd0, 14'd1000, 13'd1000, 8'd2,   1, 6'd3, 5'd3);
      waitIdle("turn_right");
      applyStimulus(14'd1000, 13'd1000, 8'd254, 0,0,1,1, 10'sd256, 10'sd0, 14'd1000, 13'd1000, 8'd254, 1, 6'd3, 5'd3);
      waitIdle("turn_cancel");

      $display("[TB] bounds and rounding");
      applyStimulus(14'd20,    13'd500,  8'd0, 0,1,0,0, 10'sd256, 10'sd0,   14'd20,    13'd500,  8'd0, 0, 6'd0, 5'd0);
      waitIdle("low_x");
      applyStimulus(14'd16380, 13'd500,  8'd0, 1,0,0,0, 10'sd256, 10'sd0,   14'd16380, 13'd500,  8'd0, 0, 6'd0, 5'd0);
      waitIdle("high_x");
      applyStimulus(14'd1000,  13'd30,   8'd0, 0,1,0,0, 10'sd0,   10'sd256, 14'd1000,  13'd30,   8'd0, 1, 6'd3, 5'd0);
      waitIdle("low_y");
      applyStimulus(14'd1000,  13'd1000, 8'd0, 1,0,0,0, -10'sd181, 10'sd0,  14'd954,   13'd1000, 8'd0, 1, 6'd3, 5'd3);
      waitIdle("floor");
      applyStimulus(14'd1000,  13'd1000, 8'd0, 1,1,0,0, 10'sd256, 10'sd256, 14'd1000,  13'd1000, 8'd0, 1, 6'd3, 5'd3);
      waitIdle("fwd_back_cancel");

      $display("[TB] reset during CHK_X");
      applyStimulus(14'd1000, 13'd1000, 8'd0, 1,0,0,0, 10'sd256, 10'sd0, 14'd1064, 13'd1000, 8'd0, 1, 6'd4, 5'd3);
      repeat (4) @(negedge clock);
      reset = 1'b0;
      scoreQ.delete();
      @(posedge clock);
      #1;
      reset = 1'b1;
      checkResetState("abort");
      applyStimulus(14'd1000, 13'd1000, 8'd0, 1,0,0,0, 10'sd256, 10'sd0, 14'd1064, 13'd1000, 8'd0, 1, 6'd4, 5'd3);
      waitIdle("after_reset");

      $display("[TB] start while busy and in DONE");
      applyStimulus(14'd2000, 13'd1000, 8'd0, 1,0,0,0, 10'sd256, 10'sd0, 14'd2064, 13'd1000, 8'd0, 1, 6'd8, 5'd3);
      pulseStart();
      repeat (4) @(negedge clock);
      pulseStart();
      waitIdle("busy_start");
      repeat (12) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/player_mover.md
# player_mover

Parametrised player-motion engine for the raycaster, and the next generation of the team's player-update logic. On a `start` pulse it samples the keyboard and applies a turn to the current pose. It fetches sin/cos from the shared trig ROM and computes a candidate step. It checks each axis against the map grid separately, so the player slides along walls, then returns the next pose with a one-cycle `done`. It sits between the keyboard decoder, the map grid RAM and the pose registers owned by the frame controller.

## Interface
Parameters:
- POS_X_W, 14, x position width (unsigned, map units)
- POS_Y_W, 13, y position width (unsigned)
- ANG_W, 8, angle width; full circle = 2^ANG_W
- CELL_SHIFT, 8, log2 of grid cell size in map units
- TRIG_W, 10, signed trig sample width; 1.0 = 2^(TRIG_W-2)
- MOVE_STEP, 64, map units per forward/back step
- TURN_STEP, 4, angle units per turn step

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request one update; sampled only in IDLE
- done  out  1  one-cycle pulse; next_* valid from this cycle
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- key_fwd, key_back, key_left, key_right  in  1 each  keyboard levels, sampled with start
- cur_pos_x  in  POS_X_W; cur_pos_y  in  POS_Y_W; cur_angle  in  ANG_W  current pose, sampled with start
- next_pos_x  out  POS_X_W; next_pos_y  out  POS_Y_W; next_angle  out  ANG_W  result pose, held until the next done
- trig_angle  out  ANG_W  trig ROM address (registered)
- trig_cos, trig_sin  in  TRIG_W each  signed ROM data, valid 1 cycle after trig_angle changes
- grid_x  out  POS_X_W-CELL_SHIFT; grid_y  out  POS_Y_W-CELL_SHIFT  registered grid read address
- grid_out  in  3  cell contents; 0 = empty, nonzero = wall; valid the cycle after the address is presented

## Operation
- FSM states: IDLE → TRIG → CALC → ADDR_X → CHK_X → ADDR_Y → CHK_Y → DONE → IDLE. Every non-IDLE state lasts exactly one cycle.
- IDLE: when start=1, latch the keys and the current pose.
  - Compute ang = cur_angle + TURN_STEP if only key_right, ang = cur_angle − TURN_STEP if only key_left, else ang = cur_angle. Arithmetic is mod 2^ANG_W.
  - Register trig_angle ← ang. Go to TRIG.
- TRIG: wait one cycle for ROM latency.
- CALC: dir = +1 if only key_fwd, −1 if only key_back, else 0.
  - dx = (dir·MOVE_STEP·trig_cos) >>> (TRIG_W−2); dy likewise with trig_sin. Use an arithmetic shift, which floors.
  - cand_x = cur_x + dx and cand_y = cur_y + dy, computed in POS_W+2 signed bits.
  - Register grid_x ← cand_x>>CELL_SHIFT and grid_y ← cur_y>>CELL_SHIFT.
- CHK_X: new_x = cand_x if 0 ≤ cand_x < 2^POS_X_W and grid_out==0, else cur_x. An out-of-range cand_x is rejected regardless of grid_out.
  - Register grid_x ← new_x>>CELL_SHIFT and grid_y ← cand_y>>CELL_SHIFT.
- CHK_Y: new_y = cand_y if it is in range and grid_out==0, else cur_y.
- DONE: next_pos_x ← new_x, next_pos_y ← new_y, next_angle ← ang. done=1.
- Opposing keys (fwd+back, left+right) cancel. With no keys pressed, the full sequence still runs and the pose is returned unchanged.
- A start asserted while busy is ignored and not queued. A start in the DONE cycle is also ignored; start is accepted again from IDLE.

## Timing
- Reset (reset=0 at a clock edge): state IDLE; done=0, busy=0; next_pos_x, next_pos_y, next_angle, trig_angle, grid_x, grid_y all 0.
- Reset mid-operation aborts immediately with no partial pose update; the cycle after release is IDLE.
- Latency: if start is sampled in cycle 0, done=1 in cycle 7. Back-to-back updates are possible every 8 cycles.
- Grid addresses are visible in ADDR_X (x check) and ADDR_Y (y check). grid_out is consumed in CHK_X and CHK_Y respectively.
- Inputs other than start, keys and pose are don't-care outside their consuming state.

## Test plan
- Defaults, pose (1000,1000,0), key_fwd, cos=256, sin=0, grid all empty → done in cycle 7, next=(1064,1000,0); grid_x=4, grid_y=3 during ADDR_X.
- Same pose and keys, cell (4,3)=1 → next=(1000,1000,0); y is unchanged.
- Wall slide: pose (1000,1000,32), key_fwd, cos=sin=181, cell (4,3)=1, cell (3,4)=0 → next=(1000,1045,32).
- Turn wrap: angle 2 with key_left → 254; angle 254 with key_right → 2; left+right together → 254 unchanged.
- Bounds: pose (20,500,0), key_back, cos=256 → cand_x=−44 is rejected, next_pos_x=20; it is rejected even when grid_out=0.
- Reset low during CHK_X → next cycle done=0, busy=0, all outputs 0. A start one cycle after release completes normally 7 cycles later. A start pulsed while busy does not produce a second done.
